bcd_updown_counter: RTL
=======================

# bcd_updown_counter

Parameterised synchronous multi-digit modulo counter with a single clock. It replaces the single-digit ripple counters for display and timebase work: DIGITS cascaded digits, each counting modulo RADIX (default decade/BCD). Adds up/down counting, a synchronous clear, parallel load with digit validation, a terminal-count output and a wrap pulse for cascading blocks.

## Interface
Parameters:
- DIGITS, 4, number of cascaded digits, legal range 1..8.
- RADIX, 10, modulus of every digit, legal range 2..16. Each digit is always 4 bits wide.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately, independent of clk.
- en  input  1  count enable, sampled on the rising clk edge.
- up  input  1  count direction: 1 = up, 0 = down.
- clr  input  1  synchronous clear.
- load  input  1  synchronous parallel load.
- din  input  4*DIGITS  load value. Digit k is din[4k+3:4k]; digit 0 is least significant.
- q  output  4*DIGITS  count value, same digit packing as din.
- tc  output  1  terminal count, combinational.
- carry  output  1  wrap pulse, registered.
- err  output  1  sticky invalid-load flag, registered.

## Operation
- Reset (reset=0):
  - q = 0, carry = 0, err = 0.
  - State holds at these values while reset is low.
  - Reset is released synchronously to the design; the first update happens on the first rising edge with reset=1.
- Per-edge priority: clr > load > en. When none of the three is asserted, q holds.
- clr=1:
  - q = 0, err = 0, carry = 0.
  - load and en are ignored on that edge.
- load=1 (with clr=0):
  - Each digit of q takes the corresponding din digit.
  - A din digit that is >= RADIX loads as 0, and err is set to 1.
  - err stays 1 until clr or reset; a later valid load does not clear it.
  - carry = 0 on a load edge. en is ignored on that edge.
- Count up (en=1, up=1):
  - Digit 0 always increments.
  - Digit k increments only when digits 0..k-1 all equal RADIX-1.
  - A digit at RADIX-1 that increments wraps to 0.
- Count down (en=1, up=0):
  - Digit 0 always decrements.
  - Digit k decrements only when digits 0..k-1 all equal 0.
  - A digit at 0 that decrements wraps to RADIX-1.
- Counter wrap:
  - Up: all digits at RADIX-1 -> all digits 0.
  - Down: all digits 0 -> all digits RADIX-1.
  - carry = 1 for exactly the cycle that q shows the wrapped value. carry = 0 on every other edge.
- tc = en & (up ? all digits == RADIX-1 : all digits == 0).
  - tc is not gated by clr or load.
  - Cascade rule: a downstream counter uses tc as its en to advance on the same edge this counter wraps.
- Invalid held state: the counter cannot reach a digit >= RADIX, given the load sanitising above. No recovery logic is required.
- Direction change: takes effect on the next enabled edge. No extra latency.

## Timing
- q, carry and err are registers. Latency is 1 clk from sampled inputs to outputs.
- tc is combinational from en, up and q, with no added latency. Cascading DIGITS*N digits through tc chains creates a combinational path; the integrator owns meeting timing on that path.
- Asynchronous reset asserted mid-count:
  - Outputs clear within the reset propagation delay, with no clk needed.
  - A carry pulse in progress is cut short.
- clr, load and en: must meet setup/hold to rising clk. No synchronisers inside the block.

## Test plan
- Reset:
  - Drive reset=0 mid-count at q=0x0037.
  - Required: q=0x0000, carry=0, err=0 immediately, before the next edge.
  - Release reset with en=1, up=1. Required: q=0x0001 after 1 edge.
- Up wrap (DIGITS=2, RADIX=10):
  - Load 0x98, then 2 edges with en=1, up=1.
  - Required: q=0x99 with tc=1, then q=0x00 with carry=1 for one cycle. Next edge: q=0x01, carry=0.
- Down wrap (DIGITS=2):
  - From q=0x10, run 11 down edges.
  - Required: 0x09 after the 1st edge, 0x00 after the 10th with tc=1, 0x99 with carry=1 after the 11th.
- Invalid load (DIGITS=2):
  - Load din=0x3C.
  - Required: q=0x30, err=1.
  - Then load 0x12. Required: q=0x12, err=1.
  - Then clr. Required: q=0x00, err=0.
- Priority:
  - clr=1, load=1, en=1 on the same edge. Required: q=0.
  - load=1, en=1 with din=0x45. Required: q=0x45, no increment, carry=0.
  - en=0 for 5 edges. Required: q holds.
- Non-decade (RADIX=6, DIGITS=2):
  - Count up from 0x00.
  - Required: 0x05 -> 0x10, and 0x55 -> 0x00 with carry=1 after 36 edges.
  - Invalid load 0x07. Required: q=0x00, err=1.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit up/down modulo counter with clear, validated parallel load,
// a combinational terminal count and a registered wrap pulse for cascading.
module bcd_updown_counter #(
   parameter int DIGITS = 4,
   parameter int RADIX  = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                up,
   input  logic                clr,
   input  logic                load,
   input  logic [4*DIGITS-1:0] din,
   output logic [4*DIGITS-1:0] q,
   output logic                tc,
   output logic                carry,
   output logic                err
);

   localparam int         W         = 4 * DIGITS;
   localparam logic [3:0] MAX_DIGIT = 4'(RADIX - 1);
   localparam logic [4:0] RADIX_W   = 5'(RADIX);

   logic [W-1:0] q_q, q_d;
   logic         carry_q, carry_d;
   logic         err_q, err_d;
   logic         all_max, all_zero;

   always_comb begin
      all_max  = 1'b1;
      all_zero = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (q_q[4*k +: 4] != MAX_DIGIT) all_max  = 1'b0;
         if (q_q[4*k +: 4] != 4'd0)      all_zero = 1'b0;
      end
   end

   // Deliberately not gated by clr or load so a downstream stage sees the
   // same enable the cascade rule expects.
   assign tc = en & (up ? all_max : all_zero);

   always_comb begin
      logic       ripple;
      logic [3:0] digit;
      q_d     = q_q;
      carry_d = 1'b0;
      err_d   = err_q;
      ripple  = 1'b1;
      digit   = 4'd0;
      if (clr) begin
         q_d   = '0;
         err_d = 1'b0;
      end else if (load) begin
         for (int k = 0; k < DIGITS; k++) begin
            digit = din[4*k +: 4];
            if ({1'b0, digit} >= RADIX_W) begin
               q_d[4*k +: 4] = 4'd0;
               err_d         = 1'b1;
            end else begin
               q_d[4*k +: 4] = digit;
            end
         end
      end else if (en) begin
         // ripple stays high while every lower digit sits at its wrap value
         for (int k = 0; k < DIGITS; k++) begin
            digit = q_q[4*k +: 4];
            if (ripple) begin
               if (up) q_d[4*k +: 4] = (digit == MAX_DIGIT) ? 4'd0 : digit + 4'd1;
               else    q_d[4*k +: 4] = (digit == 4'd0) ? MAX_DIGIT : digit - 4'd1;
            end
            ripple = ripple & (digit == (up ? MAX_DIGIT : 4'd0));
         end
         carry_d = up ? all_max : all_zero;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q     <= '0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         q_q     <= q_d;
         carry_q <= carry_d;
         err_q   <= err_d;
      end
   end

   assign q     = q_q;
   assign carry = carry_q;
   assign err   = err_q;

endmodule
